// File: rtl/axil_addr_pkg.sv
// rtl/axil_addr_pkg.sv - address map helpers shared by the AXI-Lite decode stage
// Provides the default 4-region map, a packed-map slice helper and the
// overflow-safe region match function. No ports.
package axil_addr_pkg;

  // Widest address / packed map the helpers can carry.
  localparam int MAX_AW     = 64;
  localparam int MAX_PACKED = 4096;

  localparam int DEF_M  = 4;
  localparam int DEF_AW = 32;
  localparam logic [DEF_M*DEF_AW-1:0] DEF_BASE_PACKED =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [DEF_M*DEF_AW-1:0] DEF_SIZE_PACKED = {4{32'h0000_1000}};

  // Extract field idx of width aw from a packed map, zero-extended.
  function automatic logic [MAX_AW-1:0] region_slice(
    input logic [MAX_PACKED-1:0] packed_v,
    input int                    idx,
    input int                    aw
  );
    logic [MAX_AW-1:0] r;
    r = MAX_AW'(packed_v >> (idx * aw));
    if (aw < MAX_AW) r &= (MAX_AW'(1) << aw) - MAX_AW'(1);
    return r;
  endfunction

  // Subtraction form: never forms base+size, so a region ending at the
  // top of the address space does not wrap.
  function automatic logic region_match(
    input logic [MAX_AW-1:0] base,
    input logic [MAX_AW-1:0] size,
    input logic [MAX_AW-1:0] addr,
    input logic              en
  );
    return en && (size != '0) && (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - single-region address comparator
// Ports: base/size - region window, addr - address under test,
//        en - region enable, hit - addr falls inside an enabled, non-empty region.
module addr_region_match
  import axil_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  en,
  output logic                  hit
);

  assign hit = region_match(MAX_AW'(base), MAX_AW'(size), MAX_AW'(addr), en);

endmodule

// File: rtl/addr_decode_stage.sv
// rtl/addr_decode_stage.sv - registered AXI-Lite address decode slice with error capture
// Ports: clk/rst - clock, sync active-high reset
//        in_valid/in_ready/in_addr/region_en - upstream address handshake + enable mask
//        out_valid/out_ready/out_addr/out_slave_id/out_decerr - decoded request
//        err_clear/err_valid/err_addr/err_count - sticky first-error capture and counter
module addr_decode_stage
  import axil_addr_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int ADDR_WIDTH = DEF_AW,
  parameter int SLAVE_ID_W = (M > 1) ? $clog2(M) : 1,
  parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED = DEF_BASE_PACKED,
  parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED      = DEF_SIZE_PACKED,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [M-1:0]          region_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [SLAVE_ID_W-1:0] out_slave_id,
  output logic                  out_decerr,
  input  logic                  err_clear,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam logic [MAX_PACKED-1:0] BASE_EXT = MAX_PACKED'(BASE_ADDR_PACKED);
  localparam logic [MAX_PACKED-1:0] SIZE_EXT = MAX_PACKED'(SIZE_PACKED);

  logic [M-1:0]          hit;
  logic [SLAVE_ID_W-1:0] dec_id;
  logic                  dec_err;
  logic                  accept;

  for (genvar i = 0; i < M; i++) begin : g_region
    logic [ADDR_WIDTH-1:0] base_i;
    logic [ADDR_WIDTH-1:0] size_i;
    assign base_i = ADDR_WIDTH'(region_slice(BASE_EXT, i, ADDR_WIDTH));
    assign size_i = ADDR_WIDTH'(region_slice(SIZE_EXT, i, ADDR_WIDTH));
    addr_region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .base (base_i),
      .size (size_i),
      .addr (in_addr),
      .en   (region_en[i]),
      .hit  (hit[i])
    );
  end

  // Scan high to low so the lowest matching index is the last to assign.
  always_comb begin
    dec_id  = '0;
    dec_err = 1'b1;
    for (int i = M - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_id  = SLAVE_ID_W'(i);
        dec_err = 1'b0;
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_slave_id <= '0;
      out_decerr   <= 1'b0;
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_count    <= '0;
    end else begin
      if (accept) begin
        out_valid    <= 1'b1;
        out_addr     <= in_addr;
        out_slave_id <= dec_id;
        out_decerr   <= dec_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A fresh error outranks a simultaneous clear.
      if (accept && dec_err) begin
        if (!err_valid || err_clear) err_addr <= in_addr;
        err_valid <= 1'b1;
        if (err_clear)            err_count <= ERRCNT_W'(1);
        else if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
      end else if (err_clear) begin
        err_valid <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_addr_decode_stage.sv
// tb/tb_addr_decode_stage.sv - self-checking bench for addr_decode_stage
module tb_addr_decode_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  id;
    logic        de;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  en;
    logic [1:0]  id;
    logic        de;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [3:0]  region_en = 4'hF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_addr;
  logic [1:0]  out_slave_id;
  logic        out_decerr;
  logic        err_clear = 1'b0;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_decerr2, err_valid2;
  logic [31:0] out_addr2, err_addr2;
  logic [1:0]  out_slave_id2, err_count2;

  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;
  int   delivered = 0;
  exp_t cur_exp = '0;
  exp_t e;
  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  addr_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .region_en(region_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_slave_id(out_slave_id),
    .out_decerr(out_decerr), .err_clear(err_clear), .err_valid(err_valid),
    .err_addr(err_addr), .err_count(err_count)
  );

  // Overlapping region 0 (0x0..0x1FFF), region 3 at the top of memory, 2-bit error counter.
  addr_decode_stage #(
    .ERRCNT_W(2),
    .BASE_ADDR_PACKED({32'hFFFF_F000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SIZE_PACKED({32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_2000})
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_addr(in_addr), .region_en(region_en), .out_valid(out_valid2),
    .out_ready(out_ready), .out_addr(out_addr2), .out_slave_id(out_slave_id2),
    .out_decerr(out_decerr2), .err_clear(err_clear), .err_valid(err_valid2),
    .err_addr(err_addr2), .err_count(err_count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare delivered outputs first, then record new accepts.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", 64'(out_addr), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_out", 64'({out_addr, out_slave_id, out_decerr}), 64'(e));
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        accepted++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; err_clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] en,
                      input logic [1:0] id, input logic de);
    int n = 0;
    in_valid = 1'b1; in_addr = a; region_en = en;
    cur_exp = '{addr: a, id: id, de: de};
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    logic acc;

    vecs[0] = '{32'h0000_2004, 4'hF,     2'd2, 1'b0};
    vecs[1] = '{32'h0000_0000, 4'hF,     2'd0, 1'b0};
    vecs[2] = '{32'h0000_0FFF, 4'hF,     2'd0, 1'b0};
    vecs[3] = '{32'h0000_1000, 4'hF,     2'd1, 1'b0};
    vecs[4] = '{32'h0000_3FFF, 4'hF,     2'd3, 1'b0};
    vecs[5] = '{32'h0000_4000, 4'hF,     2'd0, 1'b1};
    vecs[6] = '{32'h0000_1800, 4'b1101,  2'd0, 1'b1};
    vecs[7] = '{32'h0000_1800, 4'hF,     2'd1, 1'b0};
    vecs[8] = '{32'h0000_3000, 4'b0111,  2'd0, 1'b1};
    vecs[9] = '{32'hFFFF_FFFC, 4'hF,     2'd0, 1'b1};

    do_reset();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_addr", 64'(out_addr), 0);
    chk("rst_err_valid", 64'(err_valid), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_in_ready", 64'(in_ready), 1);

    send(32'h2004, 4'hF, 2'd2, 1'b0);
    chk("first_valid", 64'(out_valid), 1);
    chk("first_id", 64'(out_slave_id), 2);
    chk("first_decerr", 64'(out_decerr), 0);
    chk("first_addr", 64'(out_addr), 64'h2004);

    send(32'h4000, 4'hF, 2'd0, 1'b1);
    chk("err1_decerr", 64'(out_decerr), 1);
    chk("err1_id", 64'(out_slave_id), 0);
    chk("err1_valid", 64'(err_valid), 1);
    chk("err1_addr", 64'(err_addr), 64'h4000);
    chk("err1_count", 64'(err_count), 1);
    send(32'h5000, 4'hF, 2'd0, 1'b1);
    chk("err2_addr_kept", 64'(err_addr), 64'h4000);
    chk("err2_count", 64'(err_count), 2);

    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("clr_valid", 64'(err_valid), 0);
    chk("clr_count", 64'(err_count), 0);
    chk("clr_addr_kept", 64'(err_addr), 64'h4000);

    send(32'h5000, 4'hF, 2'd0, 1'b1);
    err_clear = 1'b1;
    send(32'h9000, 4'hF, 2'd0, 1'b1);
    err_clear = 1'b0;
    chk("clr_err_valid", 64'(err_valid), 1);
    chk("clr_err_addr", 64'(err_addr), 64'h9000);
    chk("clr_err_count", 64'(err_count), 1);

    for (int i = 0; i < 10; i++) send(vecs[i].addr, vecs[i].en, vecs[i].id, vecs[i].de);
    drain();

    // Stream with a 3-cycle downstream stall while 0x1000 sits in the slice.
    idx = 0; cyc = 0;
    in_valid = 1'b1; region_en = 4'hF;
    while (idx < 4 && cyc < 50) begin
      in_addr = 32'(idx) << 12;
      cur_exp = '{addr: in_addr, id: 2'(idx), de: 1'b0};
      out_ready = !(cyc >= 2 && cyc < 5);
      @(negedge clk);
      if (cyc >= 2 && cyc < 5) begin
        chk("stall_in_ready", 64'(in_ready), 0);
        chk("stall_hold_addr", 64'(out_addr), 64'h1000);
        chk("stall_hold_valid", 64'(out_valid), 1);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    chk("stream_cycles", 64'(cyc), 7);
    drain();
    chk("no_loss_dup", 64'(delivered), 64'(accepted));

    do_reset();
    repeat (5) send(32'h4000, 4'hF, 2'd0, 1'b1);
    chk("sat_count2", 64'(err_count2), 3);
    chk("count8_five", 64'(err_count), 5);
    drain();

    send(32'h1800, 4'hF, 2'd1, 1'b0);
    chk("overlap_id", 64'(out_slave_id2), 0);
    chk("overlap_decerr", 64'(out_decerr2), 0);
    send(32'hFFFF_FFFC, 4'hF, 2'd0, 1'b1);
    chk("top_region_id", 64'(out_slave_id2), 3);
    chk("top_region_decerr", 64'(out_decerr2), 0);
    chk("top_region_addr", 64'(out_addr2), 64'hFFFF_FFFC);
    drain();

    out_ready = 1'b0;
    send(32'h2000, 4'hF, 2'd2, 1'b0);
    @(negedge clk);
    chk("held_valid", 64'(out_valid), 1);
    chk("held_in_ready", 64'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_addr", 64'(out_addr), 0);
    chk("midrst_id", 64'(out_slave_id), 0);
    chk("midrst_decerr", 64'(out_decerr), 0);
    chk("midrst_err_valid", 64'(err_valid), 0);
    chk("midrst_err_addr", 64'(err_addr), 0);
    chk("midrst_err_count", 64'(err_count), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
